cache_memory_l2: RTL and testbench

// - Direct-mapped L2 between L1 data cache and main memory; serves L1 line refills.
// - Streams a 4-word line to L1 as l2_word plus a counter sequence 1..5; L1 writes word (offset+counter-1)&3 on counts 1-4, sets valid/tag on 5.
// - On an L2 miss, refills its own line from main memory first. Write-through, no write-allocate.

---
 rtl/cache_memory_l2_pkg.sv | 15 +
 rtl/cache_memory_l2_if.sv | 25 ++
 rtl/cache_memory_l2_line_store.sv | 33 +++
 rtl/cache_memory_l2.sv | 120 ++++++++++++
 tb/tb_cache_memory_l2.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/cache_memory_l2_pkg.sv
// cache_memory_l2_pkg: shared geometry, FSM encodings and refill beat codes
package cache_memory_l2_pkg;
  localparam int SETS       = 16;
  localparam int SETS_LOG2  = 4;
  localparam int TAG_W      = 32 - 2 - SETS_LOG2;
  localparam int LINE_WORDS = 4;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_SEND   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] COUNTER_IDLE   = 3'd0;
  localparam logic [2:0] COUNTER_COMMIT = 3'd5;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;
endpackage

// File: rtl/cache_memory_l2_if.sv
// cache_memory_l2_if: core/L1 side and main-memory side signals of the L2
interface cache_memory_l2_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWrite;
  logic        l1_miss;
  logic [31:0] l2_word;
  logic [2:0]  counter;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_wack;
  logic        l2_hit;
  modport slave (
    input  addr, wdata, MemWrite, l1_miss, mem_rdata, mem_rvalid, mem_wack,
    output l2_word, counter, mem_req, mem_addr, mem_we, mem_wdata, l2_hit
  );
  modport master (
    output addr, wdata, MemWrite, l1_miss, mem_rdata, mem_rvalid, mem_wack,
    input  l2_word, counter, mem_req, mem_addr, mem_we, mem_wdata, l2_hit
  );
endinterface

// File: rtl/cache_memory_l2_line_store.sv
// l2_line_store: direct-mapped line array with async line read and sync word write
module l2_line_store
  import cache_memory_l2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SETS_LOG2-1:0] i_idx,
  output logic                 o_valid,
  output logic [TAG_W-1:0]     o_tag,
  output line_t                o_line,
  input  logic                 i_we,
  input  logic [1:0]           i_wr_off,
  input  logic [31:0]          i_wdata,
  input  logic                 i_set_valid,
  input  logic [TAG_W-1:0]     i_tag
);
  logic [SETS-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [SETS];
  line_t r_data [SETS];
  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];
  // valid bits are the only state that must be cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_valid <= '0;
    else if (i_set_valid) r_valid[i_idx] <= 1'b1;
  end
  // data words and tags need no reset; they are meaningless while invalid
  always_ff @(posedge clk) begin
    if (i_we) r_data[i_idx][i_wr_off] <= i_wdata;
    if (i_set_valid) r_tag[i_idx] <= i_tag;
  end
endmodule

// File: rtl/cache_memory_l2.sv
// cache_memory_l2: direct-mapped write-through L2 streaming line refills to L1
module cache_memory_l2
  import cache_memory_l2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_memory_l2_if.slave  bus
);
  logic [2:0]  r_state;
  logic [2:0]  r_counter;
  logic [31:0] r_l2_word;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_beat;
  logic                 w_valid;
  logic [TAG_W-1:0]     w_line_tag;
  line_t                w_line;
  logic [SETS_LOG2-1:0] w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [1:0]           w_off;
  logic [1:0]           w_rd_off;
  logic                 w_hit;
  logic                 w_fill_beat;
  logic                 w_last_beat;
  logic                 w_we;
  logic [31:0]          w_next_word;
  assign w_idx       = bus.addr[SETS_LOG2+1:2];
  assign w_tag       = bus.addr[31:SETS_LOG2+2];
  assign w_off       = bus.addr[1:0];
  assign w_hit       = w_valid && (w_line_tag == w_tag);
  assign w_fill_beat = (r_state == ST_FILL) && bus.mem_rvalid;
  assign w_last_beat = w_fill_beat && (r_beat == 2'd3);
  assign w_we        = w_fill_beat || ((r_state == ST_IDLE) && bus.MemWrite && w_hit);
  // word for the next beat; the last fill beat bypasses the array since it lands this edge
  assign w_rd_off    = w_off + r_counter[1:0];
  assign w_next_word = (w_fill_beat && r_beat == w_rd_off) ? bus.mem_rdata : w_line[w_rd_off];
  assign bus.l2_hit    = w_hit;
  assign bus.counter   = r_counter;
  assign bus.l2_word   = r_l2_word;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  l2_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .i_idx      (w_idx),
    .o_valid    (w_valid),
    .o_tag      (w_line_tag),
    .o_line     (w_line),
    .i_we       (w_we),
    .i_wr_off   (w_fill_beat ? r_beat : w_off),
    .i_wdata    (w_fill_beat ? bus.mem_rdata : bus.wdata),
    .i_set_valid(w_last_beat),
    .i_tag      (w_tag)
  );
  // request FSM: writes win over misses in IDLE, refills stream 4 beats then a commit beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_counter   <= COUNTER_IDLE;
      r_l2_word   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (bus.MemWrite) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= bus.addr;
            r_mem_wdata <= bus.wdata;
            r_state     <= ST_WRITE;
          end else if (bus.l1_miss && w_hit) begin
            r_counter <= 3'd1;
            r_l2_word <= w_next_word;
            r_state   <= ST_SEND;
          end else if (bus.l1_miss) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {bus.addr[31:2], 2'b00};
            r_beat     <= '0;
            r_state    <= ST_FILL;
          end
        ST_FILL:
          if (bus.mem_rvalid) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_mem_req <= 1'b0;
              r_counter <= 3'd1;
              r_l2_word <= w_next_word;
              r_state   <= ST_SEND;
            end
          end
        ST_SEND:
          if (r_counter == 3'd4) begin
            r_counter <= COUNTER_COMMIT;
            r_l2_word <= w_line[0];
            r_state   <= ST_COMMIT;
          end else begin
            r_counter <= r_counter + 3'd1;
            r_l2_word <= w_next_word;
          end
        ST_COMMIT: begin
          r_counter <= COUNTER_IDLE;
          r_state   <= ST_IDLE;
        end
        ST_WRITE:
          if (bus.mem_wack) begin
            r_mem_we <= 1'b0;
            r_state  <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_memory_l2.sv
// tb_cache_memory_l2: scoreboarded refill/write-through checks against a memory model
module tb_cache_memory_l2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cache_memory_l2_if bus();
  cache_memory_l2 dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // main memory read responder: 2 cycles after a request, 4 consecutive words
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem[8'(bus.mem_addr[7:0] + 8'(k))];
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
      end
    end
  end
  task automatic refill(input logic [31:0] a, input logic exp_hit);
    logic [31:0] base;
    logic [1:0] w;
    logic [2:0] exp_cnt;
    logic req_seen;
    int cyc;
    base = {a[31:2], 2'b00};
    bus.addr = a;
    #1 check("l2_hit_before", {31'd0, bus.l2_hit}, {31'd0, exp_hit});
    for (int n = 1; n <= 5; n++) begin
      w = (n == 5) ? 2'd0 : 2'(a[1:0] + 2'(n - 1));
      exp_q.push_back(mem[8'(base[7:0] + {6'd0, w})]);
    end
    bus.l1_miss = 1'b1;
    exp_cnt = 3'd1;
    req_seen = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req && !req_seen) begin
        req_seen = 1'b1;
        check("mem_addr", bus.mem_addr, base);
      end
      if (bus.counter != 3'd0 && exp_q.size() != 0) begin
        check("counter", {29'd0, bus.counter}, {29'd0, exp_cnt});
        check("l2_word", bus.l2_word, exp_q.pop_front());
        exp_cnt++;
      end
    end while (bus.counter != 3'd5 && cyc < 60);
    if (cyc >= 60) check("refill_timeout", cyc, 0);
    bus.l1_miss = 1'b0;
    check("mem_req_seen", {31'd0, req_seen}, {31'd0, !exp_hit});
    if (exp_hit) check("hit_latency", cyc, 5);
    @(negedge clk);
    check("counter_back_idle", {29'd0, bus.counter}, 32'd0);
    exp_q.delete();
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
    bus.addr  = a;
    bus.wdata = d;
    #1 check("l2_hit_store", {31'd0, bus.l2_hit}, {31'd0, exp_hit});
    bus.MemWrite = 1'b1;
    @(negedge clk);
    bus.MemWrite = 1'b0;
    check("mem_we_set", {31'd0, bus.mem_we}, 32'd1);
    check("mem_addr_wr", bus.mem_addr, a);
    check("mem_wdata", bus.mem_wdata, d);
    repeat (2) @(negedge clk);
    check("mem_we_held", {31'd0, bus.mem_we}, 32'd1);
    check("mem_req_idle_wr", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_wack = 1'b1;
    @(negedge clk);
    bus.mem_wack = 1'b0;
    check("mem_we_drop", {31'd0, bus.mem_we}, 32'd0);
    mem[a[7:0]] = d;
  endtask
  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, 8'(i)};
    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'hA0 + 32'(i);
    bus.addr = '0;
    bus.wdata = '0;
    bus.MemWrite = 1'b0;
    bus.l1_miss = 1'b0;
    bus.mem_wack = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_counter", {29'd0, bus.counter}, 32'd0);
    check("rst_l2_word", bus.l2_word, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_l2_hit", {31'd0, bus.l2_hit}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    refill(32'h40, 1'b0);
    refill(32'h42, 1'b1);
    store(32'h41, 32'hDEAD, 1'b1);
    refill(32'h40, 1'b1);
    refill(32'h43, 1'b1);
    store(32'h80, 32'h1234, 1'b0);
    refill(32'h80, 1'b0);
    refill(32'h40, 1'b0);
    refill(32'h41, 1'b1);
    bus.addr = 32'h40;
    bus.l1_miss = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.counter != 3'd2 && cyc < 30);
    check("mid_send_reached", {29'd0, bus.counter}, 32'd2);
    #1 rst = 1'b0;
    #1 check("rst_mid_counter", {29'd0, bus.counter}, 32'd0);
    check("rst_mid_hit", {31'd0, bus.l2_hit}, 32'd0);
    bus.l1_miss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    refill(32'h40, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
